lzs_out_check: RTL and testbench

Synthesizable, parametrised output checker for the LZS decode path. It captures the decoder's byte-lane output stream into a small elastic buffer, pulls expected data from a reference stream, compares them lane by lane, and keeps sticky error and position records. It replaces the per-byte `$fgetc` compare in the decode bench and can run in FPGA builds, where the expected data comes from a ROM or host FIFO.

---
 rtl/lzs_pkg.sv | 20 ++
 rtl/lzs_out_check_if.sv | 29 ++
 rtl/lzs_sync_fifo.sv | 58 +++++
 rtl/lzs_out_check.sv | 184 ++++++++++++++++++
 tb/tb_lzs_out_check.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lzs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lzs_pkg : shared types for the LZS decode output checker                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lzs_pkg;
   localparam int LZF_WIDTH = 20;
   localparam int c_nb_w    = 4;

   typedef logic [c_nb_w-1:0] lzs_nb_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      HALT  = 3'd4
   } lzs_state_t;
endpackage
`default_nettype wire

// File: rtl/lzs_out_check_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lzs_out_check_if : decoder beat stream plus reference beat stream        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface lzs_out_check_if #(
   parameter int DATA_BYTES = 1
);
   import lzs_pkg::*;

   logic                    out_valid;
   logic [8*DATA_BYTES-1:0] out_data;
   lzs_nb_t                 out_nb;
   logic                    out_done;
   logic                    ref_valid;
   logic [8*DATA_BYTES-1:0] ref_data;
   logic                    ref_ready;

   modport master (
      output out_valid, out_data, out_nb, out_done, ref_valid, ref_data,
      input  ref_ready
   );

   modport slave (
      input  out_valid, out_data, out_nb, out_done, ref_valid, ref_data,
      output ref_ready
   );
endinterface
`default_nettype wire

// File: rtl/lzs_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lzs_sync_fifo : single-clock FIFO, registered read, full/empty flags     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lzs_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_pop,
   output logic      [WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty
);
   localparam int c_depth = 1 << AW;

   logic [WIDTH-1:0] r_mem [c_depth];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_rd_data;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_rd_en = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a write while full is fine then
   assign w_wr_en = i_push && (!o_full || w_rd_en);
   assign o_data  = r_rd_data;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_rd_data <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_en) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/lzs_out_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lzs_out_check : compares decoder output beats against a reference stream |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lzs_out_check
   import lzs_pkg::*;
#(
   parameter int DATA_BYTES  = 1,
   parameter int CNT_WIDTH   = LZF_WIDTH,
   parameter int FIFO_AW     = 4,
   parameter int STOP_ON_ERR = 0
) (
   input  wire logic        clk,
   input  wire logic        rst,
   lzs_out_check_if.slave   bus,
   output logic [CNT_WIDTH-1:0] chk_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic                 err,
   output logic                 ovf,
   output logic [CNT_WIDTH-1:0] first_pos,
   output logic [7:0]           first_exp,
   output logic [7:0]           first_got,
   output logic                 busy,
   output logic                 done
);
   localparam int c_dw = 8 * DATA_BYTES;
   localparam int c_fw = c_nb_w + c_dw;

   lzs_state_t           r_state;
   lzs_state_t           w_state_nxt;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_ovf_evt;
   logic                 w_halt;
   logic [c_fw-1:0]      w_rd_word;
   lzs_nb_t              w_rd_nb;
   logic [c_dw-1:0]      w_rd_data;
   logic [c_dw-1:0]      r_ref_data;
   logic                 r_cmp_vld;
   logic [DATA_BYTES-1:0] w_mis;
   logic                 w_any_mis;
   logic [c_nb_w-1:0]    w_mis_cnt;
   logic [c_nb_w-1:0]    w_low_lane;
   logic [7:0]           w_low_exp;
   logic [7:0]           w_low_got;
   logic [CNT_WIDTH:0]   w_err_sum;
   logic [CNT_WIDTH-1:0] r_chk_cnt;
   logic [CNT_WIDTH-1:0] r_err_cnt;
   logic                 r_err;
   logic                 r_ovf;
   logic [CNT_WIDTH-1:0] r_first_pos;
   logic [7:0]           r_first_exp;
   logic [7:0]           r_first_got;

   lzs_sync_fifo #(
      .WIDTH (c_fw),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (bus.out_valid),
      .i_data  ({bus.out_nb, bus.out_data}),
      .i_pop   (w_pop),
      .o_data  (w_rd_word),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_rd_nb       = w_rd_word[c_fw-1 -: c_nb_w];
   assign w_rd_data     = w_rd_word[c_dw-1:0];
   assign w_pop         = !w_empty && bus.ref_valid && ((r_state == RUN) || (r_state == DRAIN));
   assign bus.ref_ready = w_pop;
   assign w_ovf_evt     = bus.out_valid && w_full && !w_pop;

   // Descending scan so the lowest mismatching lane is the one left latched
   always_comb begin
      w_mis      = '0;
      w_mis_cnt  = '0;
      w_low_lane = '0;
      w_low_exp  = '0;
      w_low_got  = '0;
      for (int i = DATA_BYTES - 1; i >= 0; i--) begin
         if ((c_nb_w'(i) < w_rd_nb) && (w_rd_data[8*i +: 8] != r_ref_data[8*i +: 8])) begin
            w_mis[i]   = 1'b1;
            w_mis_cnt  = w_mis_cnt + c_nb_w'(1);
            w_low_lane = c_nb_w'(i);
            w_low_exp  = r_ref_data[8*i +: 8];
            w_low_got  = w_rd_data[8*i +: 8];
         end
      end
   end

   assign w_any_mis = |w_mis;
   assign w_err_sum = {1'b0, r_err_cnt} + (CNT_WIDTH+1)'(w_mis_cnt);
   assign w_halt    = (STOP_ON_ERR != 0) && r_cmp_vld && w_any_mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.out_done && bus.out_valid) begin
               w_state_nxt = DRAIN;
            end else if (bus.out_done) begin
               w_state_nxt = DONE;
            end else if (bus.out_valid) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_halt) begin
               w_state_nxt = HALT;
            end else if (bus.out_done) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (w_halt) begin
               w_state_nxt = HALT;
            end else if (w_empty && !r_cmp_vld) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = DONE;
         HALT:    w_state_nxt = HALT;
         default: w_state_nxt = IDLE;
      endcase
   end

   // A beat popped on the halting edge still completes its compare
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmp_vld   <= 1'b0;
         r_ref_data  <= '0;
         r_chk_cnt   <= '0;
         r_err_cnt   <= '0;
         r_err       <= 1'b0;
         r_ovf       <= 1'b0;
         r_first_pos <= '0;
         r_first_exp <= '0;
         r_first_got <= '0;
      end else begin
         r_cmp_vld <= w_pop;
         if (w_pop) begin
            r_ref_data <= bus.ref_data;
         end
         if (w_ovf_evt) begin
            r_ovf <= 1'b1;
         end
         if (r_cmp_vld) begin
            r_chk_cnt <= r_chk_cnt + CNT_WIDTH'(w_rd_nb);
            r_err_cnt <= w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];
            if (w_any_mis) begin
               r_err <= 1'b1;
               if (!r_err) begin
                  r_first_pos <= r_chk_cnt + CNT_WIDTH'(w_low_lane);
                  r_first_exp <= w_low_exp;
                  r_first_got <= w_low_got;
               end
            end
         end
      end
   end

   assign chk_cnt   = r_chk_cnt;
   assign err_cnt   = r_err_cnt;
   assign err       = r_err;
   assign ovf       = r_ovf;
   assign first_pos = r_first_pos;
   assign first_exp = r_first_exp;
   assign first_got = r_first_got;
   assign busy      = (r_state == RUN) || (r_state == DRAIN);
   assign done      = (r_state == DONE) || (r_state == HALT);
endmodule
`default_nettype wire

// File: tb/tb_lzs_out_check.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lzs_out_check : scoreboard bench, continue-on-error and halting DUTs  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lzs_out_check;
   typedef struct packed {
      logic [3:0]  nb;
      logic [31:0] exp;
      logic [31:0] got;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ref_v = 1'b0;

   lzs_out_check_if #(.DATA_BYTES(4)) bus_a ();
   lzs_out_check_if #(.DATA_BYTES(4)) bus_b ();

   logic [1:0][19:0] chk_cnt, err_cnt, first_pos;
   logic [1:0][7:0]  first_exp, first_got;
   logic [1:0]       err, ovf, busy, done;

   lzs_out_check #(.DATA_BYTES(4), .CNT_WIDTH(20), .FIFO_AW(2), .STOP_ON_ERR(0)) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a),
      .chk_cnt(chk_cnt[0]), .err_cnt(err_cnt[0]), .err(err[0]), .ovf(ovf[0]),
      .first_pos(first_pos[0]), .first_exp(first_exp[0]), .first_got(first_got[0]),
      .busy(busy[0]), .done(done[0])
   );

   lzs_out_check #(.DATA_BYTES(4), .CNT_WIDTH(20), .FIFO_AW(4), .STOP_ON_ERR(1)) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b),
      .chk_cnt(chk_cnt[1]), .err_cnt(err_cnt[1]), .err(err[1]), .ovf(ovf[1]),
      .first_pos(first_pos[1]), .first_exp(first_exp[1]), .first_got(first_got[1]),
      .busy(busy[1]), .done(done[1])
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int depth [2] = '{4, 16};

   beat_t q_a[$];
   beat_t q_b[$];
   beat_t fly [2];
   bit    fly_v [2];

   int         m_chk [2];
   int         m_errc [2];
   bit         m_err [2];
   bit         m_ovf [2];
   int         m_fpos [2];
   logic [7:0] m_fexp [2];
   logic [7:0] m_fgot [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic rr(input int id);
      return (id == 0) ? bus_a.ref_ready : bus_b.ref_ready;
   endfunction

   function automatic logic [31:0] pat(input int beat);
      logic [31:0] v;
      for (int l = 0; l < 4; l++) v[8*l +: 8] = 8'(4*beat + l + 'h37);
      return v;
   endfunction

   task automatic model_clear();
      q_a.delete();
      q_b.delete();
      for (int id = 0; id < 2; id++) begin
         fly_v[id] = 1'b0; m_chk[id] = 0; m_errc[id] = 0; m_err[id] = 1'b0;
         m_ovf[id] = 1'b0; m_fpos[id] = 0; m_fexp[id] = '0; m_fgot[id] = '0;
      end
   endtask

   task automatic retire(input int id);
      beat_t e;
      int mis;
      e = fly[id];
      mis = 0;
      for (int l = 0; l < 4; l++) begin
         if (l < int'(e.nb) && e.exp[8*l +: 8] != e.got[8*l +: 8]) begin
            if (!m_err[id]) begin
               m_err[id]  = 1'b1;
               m_fpos[id] = m_chk[id] + l;
               m_fexp[id] = e.exp[8*l +: 8];
               m_fgot[id] = e.got[8*l +: 8];
            end
            mis++;
         end
      end
      m_chk[id]  = (m_chk[id] + int'(e.nb)) & 32'hFFFFF;
      m_errc[id] = m_errc[id] + mis;
      check($sformatf("chk_cnt%0d", id), chk_cnt[id], m_chk[id]);
      check($sformatf("err_cnt%0d", id), err_cnt[id], m_errc[id]);
      check($sformatf("err%0d", id), err[id], m_err[id]);
      check($sformatf("first_pos%0d", id), first_pos[id], m_fpos[id]);
   endtask

   // One clock: present reference head, note pops before the edge, score after it
   task automatic cycle();
      bit pa, pb;
      bus_a.ref_valid = ref_v;
      bus_b.ref_valid = ref_v;
      bus_a.ref_data  = (q_a.size() > 0) ? q_a[0].exp : 32'h0;
      bus_b.ref_data  = (q_b.size() > 0) ? q_b[0].exp : 32'h0;
      #2;
      pa = bus_a.ref_valid && bus_a.ref_ready;
      pb = bus_b.ref_valid && bus_b.ref_ready;
      @(posedge clk);
      #1;
      for (int id = 0; id < 2; id++) begin
         if (fly_v[id]) retire(id);
         fly_v[id] = 1'b0;
      end
      if (pa) begin
         check("pop_a_has_beat", q_a.size() > 0, 1);
         if (q_a.size() > 0) begin fly[0] = q_a.pop_front(); fly_v[0] = 1'b1; end
      end
      if (pb) begin
         check("pop_b_has_beat", q_b.size() > 0, 1);
         if (q_b.size() > 0) begin fly[1] = q_b.pop_front(); fly_v[1] = 1'b1; end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic sb_push(input int id, input beat_t e);
      int sz;
      sz = (id == 0) ? q_a.size() : q_b.size();
      if (!ref_v && sz >= depth[id]) m_ovf[id] = 1'b1;
      else if (id == 0) q_a.push_back(e);
      else q_b.push_back(e);
   endtask

   task automatic drive_beat(input logic [3:0] nb, input logic [31:0] exp,
                             input logic [31:0] got, input bit last);
      beat_t e;
      e.nb = nb; e.exp = exp; e.got = got;
      bus_a.out_valid = 1'b1; bus_a.out_nb = nb; bus_a.out_data = got; bus_a.out_done = last;
      bus_b.out_valid = 1'b1; bus_b.out_nb = nb; bus_b.out_data = got; bus_b.out_done = last;
      sb_push(0, e);
      sb_push(1, e);
      cycle();
      bus_a.out_valid = 1'b0; bus_a.out_done = 1'b0;
      bus_b.out_valid = 1'b0; bus_b.out_done = 1'b0;
   endtask

   task automatic pulse_done();
      bus_a.out_done = 1'b1;
      bus_b.out_done = 1'b1;
      cycle();
      bus_a.out_done = 1'b0;
      bus_b.out_done = 1'b0;
   endtask

   function automatic logic [31:0] beat_got(input int b, input int nb, input int bad_byte,
                                            input logic [7:0] bad_val);
      logic [31:0] g;
      g = pat(b);
      for (int l = nb; l < 4; l++) g[8*l +: 8] = 8'hEE;
      if (bad_byte >= 0 && bad_byte / 4 == b) g[8*(bad_byte % 4) +: 8] = bad_val;
      return g;
   endfunction

   task automatic run_stream(input int nbeats, input int last_nb, input int bad_byte,
                             input logic [7:0] bad_val, input bit with_done);
      for (int b = 0; b < nbeats; b++) begin
         int nb;
         nb = (b == nbeats - 1) ? last_nb : 4;
         drive_beat(4'(nb), pat(b), beat_got(b, nb, bad_byte, bad_val),
                    with_done && (b == nbeats - 1));
      end
   endtask

   task automatic check_reset(input int id);
      check($sformatf("rst_chk_cnt%0d", id), chk_cnt[id], 0);
      check($sformatf("rst_err_cnt%0d", id), err_cnt[id], 0);
      check($sformatf("rst_err%0d", id), err[id], 0);
      check($sformatf("rst_ovf%0d", id), ovf[id], 0);
      check($sformatf("rst_first_pos%0d", id), first_pos[id], 0);
      check($sformatf("rst_first_exp%0d", id), first_exp[id], 0);
      check($sformatf("rst_first_got%0d", id), first_got[id], 0);
      check($sformatf("rst_busy%0d", id), busy[id], 0);
      check($sformatf("rst_done%0d", id), done[id], 0);
      check($sformatf("rst_ref_ready%0d", id), rr(id), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus_a.out_valid = 1'b0; bus_a.out_done = 1'b0;
      bus_b.out_valid = 1'b0; bus_b.out_done = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      check_reset(0);
      check_reset(1);
   endtask

   task automatic check_end(input int id, input int chk, input int errc, input logic e,
                            input logic ov);
      check($sformatf("end_chk_cnt%0d", id), chk_cnt[id], chk);
      check($sformatf("end_err_cnt%0d", id), err_cnt[id], errc);
      check($sformatf("end_err%0d", id), err[id], e);
      check($sformatf("end_ovf%0d", id), ovf[id], ov);
      check($sformatf("end_done%0d", id), done[id], 1);
      check($sformatf("end_busy%0d", id), busy[id], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_a.out_valid = 1'b0; bus_a.out_data = '0; bus_a.out_nb = '0; bus_a.out_done = 1'b0;
      bus_a.ref_valid = 1'b0; bus_a.ref_data = '0;
      bus_b.out_valid = 1'b0; bus_b.out_data = '0; bus_b.out_nb = '0; bus_b.out_done = 1'b0;
      bus_b.ref_valid = 1'b0; bus_b.ref_data = '0;
      model_clear();
      #2;
      do_reset();

      // 299 clean bytes; the final 3-lane beat carries garbage in lane 3
      ref_v = 1'b1;
      run_stream(75, 3, -1, 8'h00, 1'b1);
      idle(6);
      check_end(0, 299, 0, 1'b0, 1'b0);
      check_end(1, 299, 0, 1'b0, 1'b0);

      // Byte 0x0A corrupted: A keeps counting, B halts with one beat in flight
      do_reset();
      ref_v = 1'b1;
      run_stream(5, 4, 10, 8'h55, 1'b1);
      idle(6);
      check_end(0, 20, 1, 1'b1, 1'b0);
      check("first_pos_a", first_pos[0], 20'h0A);
      check("first_exp_a", first_exp[0], 8'h41);
      check("first_got_a", first_got[0], 8'h55);
      check("halt_chk_b", chk_cnt[1], 16);
      check("halt_first_pos_b", first_pos[1], 20'h0A);
      check("halt_first_got_b", first_got[1], 8'h55);
      check("halt_done_b", done[1], 1);
      check("halt_ref_ready_b", rr(1), 0);

      // Reference stalled for 6 beats: A overflows on the 5th; byte 5 corrupted
      do_reset();
      ref_v = 1'b0;
      for (int b = 0; b < 6; b++) begin
         drive_beat(4'd4, pat(b), beat_got(b, 4, 5, 8'hA5), 1'b0);
         check($sformatf("ovf_a_beat%0d", b), ovf[0], m_ovf[0]);
      end
      check("ovf_b_none", ovf[1], 0);
      ref_v = 1'b1;
      idle(3);
      pulse_done();
      idle(8);
      check_end(0, 16, 1, 1'b1, 1'b1);
      check("first_pos5_a", first_pos[0], 5);
      check("halt5_chk_b", chk_cnt[1], 12);
      check("halt5_first_exp_b", first_exp[1], 8'h3C);
      check("halt5_first_got_b", first_got[1], 8'hA5);
      idle(5);
      check("halt5_chk_frozen_b", chk_cnt[1], 12);
      check("halt5_ref_ready_b", rr(1), 0);
      check("halt5_done_b", done[1], 1);
      check("halt5_busy_b", busy[1], 0);

      // Reset with beats still buffered, then a fresh clean stream
      do_reset();
      ref_v = 1'b0;
      run_stream(2, 4, -1, 8'h00, 1'b0);
      check("mid_busy_a", busy[0], 1);
      do_reset();
      ref_v = 1'b1;
      run_stream(8, 4, -1, 8'h00, 1'b1);
      idle(6);
      check_end(0, 32, 0, 1'b0, 1'b0);
      check_end(1, 32, 0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
